// File: rtl/lcb_word_packer_pkg.sv
// Shared definitions for the LCB byte-pair packer and its neighbours
// (RAM wrapper and orbit reader use the same default widths).
package lcb_word_packer_pkg;

    typedef enum logic {
        S_HI = 1'b0,
        S_LO = 1'b1
    } state_t;

    localparam int HI_MARK     = 7;
    localparam int ORB_WORD_W  = 12;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_GAP_CYC = 800;

endpackage

// File: rtl/lcb_gap_timer.sv
// Idle-gap watchdog between the high and low byte of a pair: expires on the
// GAP_CYC-th consecutive enabled cycle after a clear.
module lcb_gap_timer
    import lcb_word_packer_pkg::*;
#(
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcb_word_packer.sv
// Packs LCB UART byte pairs into 12-bit orbit words and writes them into the
// active ping-pong buffer, restarting at address 0 on every buffer swap.
module lcb_word_packer
    import lcb_word_packer_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BUF_WORDS = 2048,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            iData,
    input  logic                  strob,
    input  logic                  iSW,
    output logic [ORB_WORD_W-1:0] orbWord,
    output logic                  WE,
    output logic [ADDR_W-1:0]     WrAddr,
    output logic                  oFrameDone,
    output logic [ADDR_W:0]       oLastCount,
    output logic                  oByteErr,
    output logic                  oOverflow
);

    localparam logic [ADDR_W:0] BUF_LIM = (ADDR_W + 1)'(BUF_WORDS);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    state_t          state_q;
    logic [3:0]      hi_q;
    logic [ADDR_W:0] wr_ptr_q;
    logic            sw_q;

    logic            swap;
    logic            hi_byte;
    logic            gap_clr;
    logic            gap_en;
    logic            gap_expire;
    logic [ADDR_W:0] base_ptr;

    assign swap    = iSW ^ sw_q;
    assign hi_byte = strob && iData[HI_MARK];
    assign gap_clr = (state_q == S_HI) && hi_byte;
    // A strobe on the expiry cycle is taken as the low byte, so the timer
    // only runs on idle cycles.
    assign gap_en  = (state_q == S_LO) && !strob;
    // A word completing on a swap cycle belongs to the new buffer.
    assign base_ptr = swap ? '0 : wr_ptr_q;

    lcb_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .clk      (clk),
        .rst_i    (rst),
        .clr_i    (gap_clr),
        .en_i     (gap_en),
        .expire_o (gap_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HI;
            hi_q       <= '0;
            wr_ptr_q   <= '0;
            sw_q       <= iSW;
            orbWord    <= '0;
            WE         <= 1'b0;
            WrAddr     <= '0;
            oFrameDone <= 1'b0;
            oLastCount <= '0;
            oByteErr   <= 1'b0;
            oOverflow  <= 1'b0;
        end else begin
            sw_q       <= iSW;
            WE         <= 1'b0;
            oByteErr   <= 1'b0;
            oFrameDone <= swap;
            if (swap) begin
                oLastCount <= wr_ptr_q;
                wr_ptr_q   <= '0;
                oOverflow  <= 1'b0;
            end
            case (state_q)
                S_HI: begin
                    if (hi_byte) begin
                        hi_q    <= iData[3:0];
                        state_q <= S_LO;
                    end else if (strob) begin
                        oByteErr <= 1'b1;
                    end
                end
                S_LO: begin
                    if (strob) begin
                        state_q <= S_HI;
                        if (base_ptr < BUF_LIM) begin
                            WE       <= 1'b1;
                            orbWord  <= {hi_q, iData};
                            WrAddr   <= base_ptr[ADDR_W-1:0];
                            wr_ptr_q <= base_ptr + PTR_ONE;
                        end else begin
                            oOverflow <= 1'b1;
                        end
                    end else if (gap_expire) begin
                        oByteErr <= 1'b1;
                        state_q  <= S_HI;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/lcb_word_packer.md
Name: lcb_word_packer

Overview:
- Upstream stage of the orbit ping-pong RAMs: takes the byte stream from the LCB UART receiver and assembles 12-bit orbit words from byte pairs.
- Drives the RAM write port with data, address and write-enable.
- Restarts the write pointer each time the orbit reader swaps buffers, and reports frame word count, framing errors and overflow.
- Runs entirely in the 80 MHz receive clock domain.

Parameters:
ADDR_W, 11, RAM address width.
BUF_WORDS, 2048, words per buffer half; legal range 1..2**ADDR_W.
GAP_CYC, 800, idle clk cycles between high and low byte before the pair is abandoned (10 us at 80 MHz).

Ports:
clk  in  1  80 MHz receive clock.
rst  in  1  synchronous, active-high reset.
iData  in  8  received byte, valid when strob=1.
strob  in  1  one-cycle byte-valid pulse from UART receiver.
iSW  in  1  buffer-select level from orbit reader, already synchronised to clk.
orbWord  out  12  assembled word to RAM data input.
WE  out  1  one-cycle RAM write enable.
WrAddr  out  ADDR_W  RAM write address.
oFrameDone  out  1  one-cycle pulse on each buffer swap.
oLastCount  out  ADDR_W+1  words written into the buffer just closed.
oByteErr  out  1  one-cycle pulse on framing error.
oOverflow  out  1  sticky flag: a word was dropped because the buffer was full; cleared on swap.

Behaviour:
- Reset values:
  - orbWord=0, WE=0, WrAddr=0, oFrameDone=0, oLastCount=0, oByteErr=0, oOverflow=0.
  - State=S_HI, wr_ptr=0, gap counter=0.
  - sw_d (registered iSW) is loaded with iSW, so no swap is seen on the first cycle after reset.
- Byte format:
  - High byte: bit7=1, bits6:4 ignored, bits3:0 = word[11:8].
  - Low byte: any value = word[7:0].
- FSM:
  - S_HI, strob with iData[7]=1: latch hi nibble, clear gap counter, go to S_LO.
  - S_HI, strob with iData[7]=0: byte discarded, oByteErr pulses next cycle, stay in S_HI.
  - S_LO, strob: form word {hi, iData}, go to S_HI.
  - S_LO, no strob: gap counter increments. When it reaches GAP_CYC-1: oByteErr pulses, go to S_HI, pair discarded.
  - A strob on the same cycle the gap expires wins: the byte is taken as the low byte.
- Write, in the cycle after the low-byte strob (latency 1):
  - If wr_ptr<BUF_WORDS: WE=1, orbWord=word, WrAddr=wr_ptr, then wr_ptr increments.
  - Else: WE=0 and oOverflow is set.
  - WE is held 0 on every other cycle; orbWord and WrAddr hold their last values.
- Swap detection:
  - Any change of iSW relative to sw_d is a swap.
  - On a swap cycle: oFrameDone=1 next cycle, oLastCount=wr_ptr, wr_ptr=0, oOverflow cleared.
  - The FSM state is not disturbed; a pair in progress completes into the new buffer.
- Simultaneous swap and word completion:
  - The word goes to address 0 of the new buffer and wr_ptr becomes 1.
  - oLastCount excludes that word.
- Width rules:
  - wr_ptr is ADDR_W+1 bits, so a count of BUF_WORDS is representable.
  - WrAddr = wr_ptr[ADDR_W-1:0]. wr_ptr never wraps; it saturates at BUF_WORDS.
- Reset asserted mid-pair or mid-frame: all state returns to reset values on the next clk edge; no WE is issued.

Decomposition:
- Shared package holds:
  - State enum S_HI/S_LO.
  - HI_MARK bit index (7).
  - ORB_WORD_W=12.
  - Default ADDR_W and GAP_CYC so the RAM wrapper and the orbit reader use identical widths.
- Natural sub-module: lcb_gap_timer, the GAP_CYC counter with clear/enable/expire.
- Pair FSM and write-pointer logic stay in the top module.

Test Plan:
- Reset, then bytes 0x8A,0x5C and 0x83,0xFF: WE at 0x000 with word 0xA5C, then at 0x001 with word 0x3FF; 1-cycle latency after each low-byte strob.
- Byte 0x12 while in S_HI: oByteErr pulses once, no WE. Then 0x81,0x00: word 0x100 written at 0x000.
- 0x85 followed by 800 idle cycles: oByteErr at gap expiry, no WE. A subsequent 0x34 is rejected as an error.
- Write 5 words, toggle iSW: oFrameDone pulse, oLastCount=5. The next word lands at WrAddr=0.
- BUF_WORDS=4, write 6 words: 4 WEs at 0..3, oOverflow set at the 5th word. A swap gives oLastCount=4 and oOverflow=0.
- Low-byte strob on the same cycle as the iSW toggle: word at address 0, oLastCount excludes it. Separately, rst asserted while in S_LO: no WE, all outputs 0 next cycle.
